// File: rtl/serial_frame_pkg.sv
// serial_frame_pkg
// Shared types and line-level constants for the serial frame link.
// Contents:
//   state_t     - receiver FSM states (PARITY is only reached when the
//                 PARITY_EN macro is defined)
//   IDLE_LEVEL  - level of an idle line
//   START_LEVEL - level of a start bit
//   STOP_LEVEL  - level of a stop bit
package serial_frame_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/serial_frame_rx_sipo_shift.sv
// sipo_shift
// WIDTH-bit serial-in / parallel-out shift register. New bits enter at the
// MSB end, so after WIDTH shifts of an LSB-first stream the word sits in
// natural bit order.
// Ports:
//   clk   - clock, rising edge
//   clr   - synchronous active-low clear (dominates shift)
//   shift - shift enable
//   din   - serial input bit
//   q     - parallel contents
module sipo_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             shift,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  // A one-bit register has no lower bits to move along, so it is a
  // plain enabled load.
  generate
    if (WIDTH == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (!clr) begin
          q <= '0;
        end else if (shift) begin
          q <= din;
        end
      end
    end else begin : g_multi
      always_ff @(posedge clk) begin
        if (!clr) begin
          q <= '0;
        end else if (shift) begin
          q <= {din, q[WIDTH-1:1]};
        end
      end
    end
  endgenerate

endmodule

// File: rtl/serial_frame_rx.sv
// serial_frame_rx
// Serial frame receiver: start bit (0), WIDTH data bits LSB first, optional
// even-parity bit, stop bit (1). The line is sampled only on clock edges
// where the external strobe en is high, so any bit rate up to one bit per
// clock is supported.
// Configuration macro: PARITY_EN - when defined, an even-parity bit follows
// the data bits and mismatches raise par_err; when undefined, no parity bit
// is expected and par_err is tied low.
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous active-low reset
//   en        - bit-sample strobe
//   d         - synchronised serial line, idle high
//   q         - last good received word
//   valid     - one-cycle pulse, q holds a new good word
//   frame_err - one-cycle pulse, stop bit sampled low
//   par_err   - one-cycle pulse, parity mismatch
//   busy      - frame in progress
module serial_frame_rx
  import serial_frame_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             d,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic             frame_err,
  output logic             par_err,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic             shift_en;
  logic             par_ok;

  assign shift_en = en && (state == DATA);
  assign busy     = (state != IDLE);

  sipo_shift #(
    .WIDTH(WIDTH)
  ) u_shift (
    .clk  (clk),
    .clr  (rst),
    .shift(shift_en),
    .din  (d),
    .q    (shreg)
  );

`ifdef PARITY_EN
  logic par_bit;

  // Even parity: data bits and parity bit together must XOR to zero.
  assign par_ok = ~(^{shreg, par_bit});
`else
  assign par_ok  = 1'b1;
  assign par_err = 1'b0;
`endif

  // Frame FSM with the counter and all registered outputs. Pulses default
  // low every cycle so they can only be high for the one cycle after the
  // stop-bit sample.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      q         <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
`ifdef PARITY_EN
      par_err   <= 1'b0;
      par_bit   <= 1'b0;
`endif
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
`ifdef PARITY_EN
      par_err   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (en && (d == START_LEVEL)) begin
            state <= DATA;
            cnt   <= '0;
          end
        end

        // The shift itself happens in sipo_shift; here we only count.
        // The counter stops at WIDTH, which still fits in CW bits.
        DATA: begin
          if (en) begin
            cnt <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1)) begin
`ifdef PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end

`ifdef PARITY_EN
        PARITY: begin
          if (en) begin
            par_bit <= d;
            state   <= STOP;
          end
        end
`endif

        // Framing and parity faults are reported independently and can
        // fire together; either one keeps q at its previous good word.
        STOP: begin
          if (en) begin
            state <= IDLE;
            if ((d == STOP_LEVEL) && par_ok) begin
              q     <= shreg;
              valid <= 1'b1;
            end
            if (d != STOP_LEVEL) begin
              frame_err <= 1'b1;
            end
`ifdef PARITY_EN
            if (!par_ok) begin
              par_err <= 1'b1;
            end
`endif
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx
// Self-checking bench for serial_frame_rx with WIDTH=8. A fixed table of
// frames with hand-derived outcomes is followed by hand-written reset
// sequences and a batch of random frames whose outcomes come from a small
// frame-level model. Honours the PARITY_EN macro like the design.
module tb_serial_frame_rx;
  import serial_frame_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         en;
  logic         d;
  logic [W-1:0] q;
  logic         valid;
  logic         frame_err;
  logic         par_err;
  logic         busy;

  int total = 0;
  int bad   = 0;
  int valid_seen = 0;

  logic [W-1:0] exp_q;
  logic         exp_busy;

  typedef struct {
    logic [W-1:0] word;
    logic         stop;
    logic         flip;
    int           gap;
    logic         e_valid;
    logic         e_ferr;
    logic         e_perr;
    logic [W-1:0] e_q;
  } vec_t;

  vec_t vecs[$];

  serial_frame_rx #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .d        (d),
    .q        (q),
    .valid    (valid),
    .frame_err(frame_err),
    .par_err  (par_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

  // Drive one clock worth of inputs, then sample just after the edge.
  task automatic applyStimulus(input logic en_v, input logic d_v);
    en = en_v;
    d  = d_v;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic check_all(input logic ev, input logic ef, input logic ep);
    if (valid === 1'b1) valid_seen++;
    checkOutput("q", 32'(q), 32'(exp_q));
    checkOutput("valid", 32'(valid), 32'(ev));
    checkOutput("frame_err", 32'(frame_err), 32'(ef));
    checkOutput("par_err", 32'(par_err), 32'(ep));
    checkOutput("busy", 32'(busy), 32'(exp_busy));
  endtask

  // Sends one frame; after every strobed bit, gap idle clocks with en=0
  // and random junk on the line.
  task automatic send_frame(input logic [W-1:0] word, input logic stop,
                            input logic flip, input int gap,
                            input logic ev, input logic ef, input logic ep,
                            input logic [W-1:0] eq);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < W; i++) bits.push_back(word[i]);
`ifdef PARITY_EN
    bits.push_back((^word) ^ flip);
`endif
    bits.push_back(stop);
    for (int i = 0; i < bits.size(); i++) begin
      applyStimulus(1'b1, bits[i]);
      if (i == bits.size() - 1) begin
        exp_busy = 1'b0;
        exp_q    = eq;
        check_all(ev, ef, ep);
      end else begin
        exp_busy = 1'b1;
        check_all(1'b0, 1'b0, 1'b0);
      end
      for (int g = 0; g < gap; g++) begin
        applyStimulus(1'b0, 1'($urandom));
        check_all(1'b0, 1'b0, 1'b0);
      end
    end
  endtask

  initial begin
    logic [W-1:0] w;
    logic         s;
    logic         f;
    logic         pbit;
    logic         pok;
    logic         mv;
    logic         mf;
    logic         mp;
    int           v0;

    rst = 1'b0;
    en  = 1'b0;
    d   = IDLE_LEVEL;
    exp_q    = '0;
    exp_busy = 1'b0;

    // Reset held three cycles with the line toggling and the strobe on.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'(i % 2));
      check_all(1'b0, 1'b0, 1'b0);
    end
    rst = 1'b1;
    applyStimulus(1'b1, IDLE_LEVEL);
    check_all(1'b0, 1'b0, 1'b0);

    // word, stop, flip, gap, valid, ferr, perr, q after
    vecs.push_back('{8'hA5, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'hA5});
    vecs.push_back('{8'h3C, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 8'hA5});
    vecs.push_back('{8'h81, 1'b1, 1'b0, 3, 1'b1, 1'b0, 1'b0, 8'h81});
    vecs.push_back('{8'h00, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0, 8'h00});
    vecs.push_back('{8'hFF, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'hFF});
    vecs.push_back('{8'h12, 1'b0, 1'b0, 2, 1'b0, 1'b1, 1'b0, 8'hFF});
`ifdef PARITY_EN
    vecs.push_back('{8'h07, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'h07});
    vecs.push_back('{8'h07, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b1, 8'h07});
    vecs.push_back('{8'h0F, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b1, 8'h07});
    vecs.push_back('{8'h33, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b1, 8'h07});
`endif
    for (int i = 0; i < vecs.size(); i++) begin
      send_frame(vecs[i].word, vecs[i].stop, vecs[i].flip, vecs[i].gap,
                 vecs[i].e_valid, vecs[i].e_ferr, vecs[i].e_perr,
                 vecs[i].e_q);
    end

    // Idle line with the strobe on must not start a frame.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, IDLE_LEVEL);
      check_all(1'b0, 1'b0, 1'b0);
    end

    // Reset after four data bits: frame dropped, q cleared, no pulse.
    applyStimulus(1'b1, 1'b0);
    exp_busy = 1'b1;
    check_all(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'(i % 2));
      check_all(1'b0, 1'b0, 1'b0);
    end
    rst = 1'b0;
    applyStimulus(1'b1, 1'b1);
    exp_busy = 1'b0;
    exp_q    = '0;
    check_all(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    v0 = valid_seen;
    send_frame(8'h5A, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'h5A);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, IDLE_LEVEL);
      check_all(1'b0, 1'b0, 1'b0);
    end
    checkOutput("midreset_pulses", 32'(valid_seen - v0), 32'd1);

    // Random frames judged by the frame-level rules.
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        applyStimulus(1'b1, IDLE_LEVEL);
        check_all(1'b0, 1'b0, 1'b0);
      end
      w = W'($urandom);
      s = ($urandom_range(0, 4) != 0);
`ifdef PARITY_EN
      f    = ($urandom_range(0, 3) == 0);
      pbit = (^w) ^ f;
      pok  = ((^w) ^ pbit) == 1'b0;
`else
      f    = 1'b0;
      pbit = 1'b0;
      pok  = 1'b1;
`endif
      mv = s && pok;
      mf = !s;
      mp = !pok;
      send_frame(w, s, f, int'($urandom_range(0, 2)), mv, mf, mp,
                 mv ? w : exp_q);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_frame_rx.md
# serial_frame_rx

Serial frame receiver: recovers fixed-width data words from a single-bit serial line framed as start bit (0), WIDTH data bits LSB first, optional even-parity bit, and stop bit (1). It is the receiving end of the team's serial frame link. It sits after the line synchroniser and delivers one registered parallel word plus a one-cycle valid strobe per good frame. Bit timing comes from an external sample strobe, so the block runs at any bit rate up to one bit per clock.

## Interface
Parameters:
- WIDTH, 8, data bits per frame (≥1)

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-low reset
- en  input  1  bit-sample strobe; line `d` is sampled only on edges where en=1
- d  input  1  serial line, idle high, already synchronised to clk
- q  output  WIDTH  last good received word
- valid  output  1  one-cycle pulse: q updated with a new good word
- frame_err  output  1  one-cycle pulse: stop bit sampled as 0
- par_err  output  1  one-cycle pulse: parity mismatch (constant 0 without PARITY_EN)
- busy  output  1  high while a frame is in progress (state ≠ IDLE)

## Operation
- Reset (rst=0 at rising edge): state=IDLE, bit counter=0, shift register=0, q=0, valid=0, frame_err=0, par_err=0, busy=0. Reset overrides all other inputs. Reset mid-frame abandons the frame with no pulse.
- FSM states: IDLE, DATA, PARITY (only with PARITY_EN), STOP.
- IDLE: on en=1 and d=0, go to DATA with counter=0. Otherwise stay.
- DATA: on en=1, shift d into the MSB end of the shift register (LSB-first reception) and increment the counter. After the WIDTH-th bit, go to PARITY if PARITY_EN is defined, else to STOP.
- PARITY: on en=1, capture d as the parity bit and go to STOP.
- STOP: on en=1, return to IDLE and classify the frame:
  - d=1 and parity ok: load q ← shift register, valid=1.
  - d=0: frame_err=1; q is unchanged.
  - d=1 with a parity mismatch: par_err=1; q is unchanged.
  - d=0 with a parity mismatch: frame_err=1 and par_err=1 together.
- Edges with en=0 hold all state. Pulse outputs are 0 on every cycle except the one that follows a stop-bit sample.
- Counter width is $clog2(WIDTH+1). The counter does not wrap within a frame.
- Back-to-back frames: the first en=1 edge after STOP is evaluated in IDLE, so a start bit can immediately follow a stop bit.

## Timing
- valid, frame_err and par_err are registered. They go high in the clock cycle right after the rising edge that samples the stop bit, and last exactly one cycle.
- q changes in the same cycle that valid goes high, and holds until the next good frame.
- Frame length is 2+WIDTH strobes without PARITY_EN and 3+WIDTH with it.
- busy goes high the cycle after the start-bit sample and low the cycle after the stop-bit sample.
- en=1 on every clock is legal: one bit per clock.

## Configuration
- PARITY_EN defined: an even-parity bit follows the data bits. The parity check is XOR of the WIDTH data bits and the parity bit, which must equal 0. A mismatch raises par_err and suppresses valid.
- PARITY_EN undefined: the PARITY state is not built, par_err is tied 0, and no parity bit is expected on the line.

## Structure
- Package serial_frame_pkg:
  - state enum (IDLE, DATA, PARITY, STOP)
  - constants: IDLE_LEVEL=1'b1, START_LEVEL=1'b0, STOP_LEVEL=1'b1
- One sub-module, sipo_shift: a WIDTH-bit serial-in/parallel-out shift register with shift-enable and synchronous active-low clear. The FSM, counter and output registers stay in the top module.

## Test plan
All scenarios use WIDTH=8 and en=1 every clock unless stated otherwise.
- Reset: hold rst=0 for 3 cycles with d toggling → q=0x00, valid=0, busy=0 throughout.
- Good frame: d = 0,1,0,1,0,0,1,0,1,1 (0xA5 LSB first, plus stop) → q=0xA5 and a single valid pulse one cycle after the stop sample; frame_err=0.
- Framing error: send 0x3C with the stop bit as 0 → frame_err pulses, valid=0, q keeps its previous value 0xA5.
- Strobe gating: en=1 every 4th clock, frame 0x81 → q=0x81; the line is ignored on en=0 edges, including glitches injected on d.
- Reset mid-frame: drop rst after 4 data bits, then send 0x5A → only 0x5A is reported, with exactly one valid pulse.
- Parity (PARITY_EN): 0x07 with parity bit 1 → valid, q=0x07. 0x07 with parity bit 0 → par_err pulse, no valid.
